// File: rtl/car_lane_scheduler.sv
// car_lane_scheduler: per-lane car motion requests from one tick divider, round-robin onto one shared position updater
// Ports:
//   clk_in, reset_in     clock and synchronous active-high reset
//   enable               game running; low parks every lane at X_START (overrun kept)
//   level                0 selects a 20 px step, any other value a 40 px step
//   car_l, car_r         per-lane left/right edges, lane i in bits [10*i+9:10*i]
//   update_valid         one-cycle pulse when a lane position changed
//   update_lane          lane index of the last update
//   overrun              sticky: a lane requested while its previous request was still pending
module car_lane_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int TICK_DIV  = 15000000,
    parameter int X_START   = 20,
    parameter int X_MAX     = 561,
    parameter int CAR_W     = 60
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     enable,
    input  logic [2:0]               level,
    output logic [10*NUM_LANES-1:0]  car_l,
    output logic [10*NUM_LANES-1:0]  car_r,
    output logic                     update_valid,
    output logic [2:0]               update_lane,
    output logic                     overrun
);
    localparam int TW = $clog2(TICK_DIV);
    logic [TW-1:0]                 tick_cnt_q, tick_cnt_d;
    logic [NUM_LANES-1:0][2:0]     pcnt_q, pcnt_d;
    logic [NUM_LANES-1:0][9:0]     car_l_q, car_l_d;
    logic [NUM_LANES-1:0]          pending_q, pending_d, req, gnt_oh;
    logic [2:0]                    rr_q, rr_d, gnt, update_lane_q;
    logic                          update_valid_q, overrun_q, base_tick, gnt_v, ovr;
    logic [9:0]                    step;
    assign car_l        = car_l_q;
    assign update_valid = update_valid_q;
    assign update_lane  = update_lane_q;
    assign overrun      = overrun_q;
    always_comb begin
        base_tick  = enable && tick_cnt_q == TW'(TICK_DIV - 1);
        tick_cnt_d = base_tick ? '0 : tick_cnt_q + 1'b1;
        step       = (level == 3'd0) ? 10'd20 : 10'd40;
        gnt_v      = 1'b0;
        gnt        = '0;
        // For the current pointer value, scan from farthest to nearest so the nearest pending lane wins.
        for (int j = 0; j < NUM_LANES; j++)
            for (int k = NUM_LANES - 1; k >= 0; k--)
                if (rr_q == 3'(j) && pending_q[(j + k) % NUM_LANES]) begin
                    gnt_v = 1'b1;
                    gnt   = 3'((j + k) % NUM_LANES);
                end
        rr_d = !gnt_v ? rr_q : (gnt == 3'(NUM_LANES - 1)) ? 3'd0 : gnt + 3'd1;
        for (int i = 0; i < NUM_LANES; i++) begin
            req[i]       = base_tick && pcnt_q[i] == 3'(i);
            pcnt_d[i]    = !base_tick ? pcnt_q[i] : req[i] ? 3'd0 : pcnt_q[i] + 3'd1;
            gnt_oh[i]    = gnt_v && gnt == 3'(i);
            // A request arriving in the grant cycle of the same lane survives as a fresh pending entry.
            pending_d[i] = req[i] | (pending_q[i] & ~gnt_oh[i]);
            car_l_d[i]   = !gnt_oh[i] ? car_l_q[i] :
                           (car_l_q[i] >= 10'(X_MAX)) ? 10'(X_START) : car_l_q[i] + step;
            car_r[10*i +: 10] = car_l_q[i] + 10'(CAR_W);
        end
        ovr = |(req & pending_q & ~gnt_oh);
    end
    always_ff @(posedge clk_in) begin
        if (reset_in || !enable) begin
            tick_cnt_q     <= '0;
            pcnt_q         <= '0;
            pending_q      <= '0;
            rr_q           <= '0;
            car_l_q        <= {NUM_LANES{10'(X_START)}};
            update_valid_q <= 1'b0;
            update_lane_q  <= '0;
            overrun_q      <= reset_in ? 1'b0 : overrun_q;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            pcnt_q         <= pcnt_d;
            pending_q      <= pending_d;
            rr_q           <= rr_d;
            car_l_q        <= car_l_d;
            update_valid_q <= gnt_v;
            update_lane_q  <= gnt_v ? gnt : update_lane_q;
            overrun_q      <= overrun_q | ovr;
        end
    end
endmodule

// File: tb/tb_car_lane_scheduler.sv
// tb_car_lane_scheduler: scoreboard bench for car_lane_scheduler (main instance TICK_DIV=4, overrun instance TICK_DIV=2)
module tb_car_lane_scheduler;
    localparam int N  = 4;
    localparam int CW = 60;
    logic           clk_in = 1'b0;
    logic           reset_in, enable, enable2;
    logic [2:0]     level;
    logic [10*N-1:0] car_l, car_r, car_l2, car_r2;
    logic           update_valid, update_valid2, overrun, overrun2;
    logic [2:0]     update_lane, update_lane2;
    always #5 clk_in = ~clk_in;
    car_lane_scheduler #(.NUM_LANES(N), .TICK_DIV(4), .X_START(20), .X_MAX(561), .CAR_W(CW)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable(enable), .level(level),
        .car_l(car_l), .car_r(car_r), .update_valid(update_valid),
        .update_lane(update_lane), .overrun(overrun)
    );
    car_lane_scheduler #(.NUM_LANES(N), .TICK_DIV(2), .X_START(20), .X_MAX(561), .CAR_W(CW)) dut2 (
        .clk_in(clk_in), .reset_in(reset_in), .enable(enable2), .level(level),
        .car_l(car_l2), .car_r(car_r2), .update_valid(update_valid2),
        .update_lane(update_lane2), .overrun(overrun2)
    );
    typedef struct {int lane; int l;} exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad = 0;
    int cur = 0;
    bit lane0_only = 1'b0;
    // Expected update order for base ticks 1..12 at level 0 (round-robin pointer traced by hand).
    int a_lane[25] = '{0, 1,0, 2,0, 1,3,0, 0, 1,2,0, 0, 1,3,0, 2,0, 1,0, 0, 1,2,3,0};
    int a_pos[25]  = '{40, 40,60, 40,80, 60,40,100, 120, 80,60,140, 160, 100,60,180, 80,200, 120,220, 240, 140,100,80,260};
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic int lf(input logic [10*N-1:0] v, input int i);
        return int'(v[10*i +: 10]);
    endfunction
    task automatic adv(input int k);
        while (cur < k) begin
            @(negedge clk_in);
            cur++;
        end
    endtask
    always @(negedge clk_in) begin
        if (!reset_in && update_valid && (!lane0_only || update_lane == 3'd0)) begin
            if (sb.size() == 0) chk("unexpected_update_lane", int'(update_lane), -1);
            else begin
                e = sb.pop_front();
                chk("upd_lane", int'(update_lane), e.lane);
                chk("upd_car_l", lf(car_l, e.lane), e.l);
                chk("upd_car_r", lf(car_r, e.lane), e.l + CW);
            end
        end
    end
    initial begin
        reset_in = 1'b1;
        enable   = 1'b1;
        enable2  = 1'b1;
        level    = 3'd0;
        for (int i = 0; i < 25; i++) sb.push_back('{lane: a_lane[i], l: a_pos[i]});
        for (int k = 1; k <= 15; k++) sb.push_back('{lane: 0, l: 260 + 20 * k});
        sb.push_back('{lane: 0, l: 600});
        sb.push_back('{lane: 0, l: 20});
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        for (int i = 0; i < N; i++) begin
            chk("rst_car_l", lf(car_l, i), 20);
            chk("rst_car_r", lf(car_r, i), 80);
            chk("rst_car_l2", lf(car_l2, i), 20);
        end
        chk("rst_valid", int'(update_valid), 0);
        chk("rst_lane", int'(update_lane), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset_in = 1'b0;
        adv(4);
        chk("first_upd_early", int'(update_valid), 0);
        adv(5);
        chk("first_upd", int'(update_valid), 1);
        chk("ovr2_early", int'(overrun2), 0);
        adv(20);
        chk("ovr2_set", int'(overrun2), 1);
        enable2 = 1'b0;
        adv(22);
        chk("ovr2_sticky", int'(overrun2), 1);
        chk("park2_valid", int'(update_valid2), 0);
        for (int i = 0; i < N; i++) chk("park2_car_l", lf(car_l2, i), 20);
        adv(54);
        chk("sb_after_tick13", sb.size(), 16);
        lane0_only = 1'b1;
        adv(110);
        chk("lane0_at_560", lf(car_l, 0), 560);
        level = 3'd1;
        adv(120);
        chk("overrun_none", int'(overrun), 0);
        enable = 1'b0;
        adv(121);
        for (int i = 0; i < N; i++) begin
            chk("park_car_l", lf(car_l, i), 20);
            chk("park_car_r", lf(car_r, i), 80);
        end
        chk("park_valid", int'(update_valid), 0);
        chk("sb_drained", sb.size(), 0);
        enable = 1'b1;
        sb.push_back('{lane: 0, l: 60});
        for (int c = 122; c <= 125; c++) begin
            adv(c);
            chk("restart_quiet", int'(update_valid), 0);
        end
        adv(126);
        chk("restart_upd", int'(update_valid), 1);
        chk("restart_lane", int'(update_lane), 0);
        enable = 1'b0;
        adv(128);
        chk("sb_final", sb.size(), 0);
        chk("overrun_final", int'(overrun), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
